// File: rtl/shl_tb_pkg.sv
// Shared definitions for the SHL stimulus generator: FSM encoding, LFSR taps,
// default seeds and the Galois step used by every LFSR in the slice.
package shl_tb_pkg;

    localparam logic [31:0] LFSR_TAPS   = 32'h8020_0003;
    localparam logic [31:0] DEF_SEED_A  = 32'h0000_0001;
    localparam logic [31:0] DEF_SEED_SH = 32'h0000_0003;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_A_ONLY   = 3'd1;
    localparam logic [2:0] ST_SH_ONLY  = 3'd2;
    localparam logic [2:0] ST_A_AND_SH = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/shl_stim_gen_lfsr32.sv
// 32-bit Galois LFSR. Load and step together install the successor of the
// seed, so the seed itself can be consumed as a draw on the load cycle.
module lfsr32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] seed,
    output logic [31:0] state
);
    import shl_tb_pkg::*;

    always_ff @(posedge clk) begin
        if (rst)
            state <= 32'h0000_0001;
        else if (load)
            state <= step ? lfsr_next(seed) : seed;
        else if (step)
            state <= lfsr_next(state);
    end

endmodule

// File: rtl/shl_stim_gen.sv
// Stimulus generator for the SHL unit: three-phase seeded vector sequence
// (operand only, shift only, both) with expected result and ready/valid stall.
module shl_stim_gen #(
    parameter int          DATAWIDTH   = 32,
    parameter int          NUM_VECTORS = 256,
    parameter logic [31:0] SEED_A      = 32'h0000_0001,
    parameter logic [31:0] SEED_SH     = 32'h0000_0003
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 ready,
    output logic [DATAWIDTH-1:0] a,
    output logic [DATAWIDTH-1:0] sh_amt,
    output logic [DATAWIDTH-1:0] d_ref,
    output logic                 valid,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          vec_count
);
    import shl_tb_pkg::*;

    localparam int SW = $clog2(DATAWIDTH);

    logic [2:0]           state;
    logic [31:0]          lfsr_a, lfsr_s, src_a, accepted;
    logic                 ld, accept, last, take_a, take_s;
    logic [63:0]          a_wide;
    logic [SW:0]          sh_small;
    logic [DATAWIDTH-1:0] a_draw, sh_draw, d_nxt;
    logic                 unused_bits;

    assign ld     = (state == ST_IDLE || state == ST_DONE) && start;
    assign accept = valid && ready;
    // Internal count does not saturate, so runs beyond 65535 still terminate.
    assign last   = accept && (accepted == 32'(NUM_VECTORS - 1));

    // A_ONLY -> SH_ONLY keeps the operand; every other running step draws one.
    assign take_a = ld || (accept && !last && state != ST_A_ONLY);
    assign take_s = accept && !last;

    lfsr32 lfsr_a_i (
        .clk  (clk),
        .rst  (rst),
        .load (ld),
        .step (take_a),
        .seed (SEED_A),
        .state(lfsr_a)
    );

    lfsr32 lfsr_s_i (
        .clk  (clk),
        .rst  (rst),
        .load (ld),
        .step (take_s),
        .seed (SEED_SH),
        .state(lfsr_s)
    );

    assign src_a    = ld ? SEED_A : lfsr_a;
    assign a_wide   = {src_a, src_a};
    assign a_draw   = a_wide[DATAWIDTH-1:0];
    assign sh_small = {1'b0, lfsr_s[SW-1:0]} + (SW+1)'(1);
    assign sh_draw  = DATAWIDTH'(sh_small);
    // A shift of exactly DATAWIDTH drops every bit, giving zero.
    assign d_nxt    = (take_a ? a_draw : a) << sh_draw;

    assign unused_bits = ^{lfsr_s[31:SW], a_wide};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            a         <= '0;
            sh_amt    <= '0;
            d_ref     <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            vec_count <= '0;
            accepted  <= '0;
        end else if (ld) begin
            state     <= ST_A_ONLY;
            a         <= a_draw;
            sh_amt    <= '0;
            d_ref     <= a_draw;
            valid     <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            vec_count <= '0;
            accepted  <= '0;
        end else if (accept) begin
            accepted <= accepted + 32'd1;
            if (vec_count != 16'hFFFF)
                vec_count <= vec_count + 16'd1;
            if (last) begin
                state <= ST_DONE;
                valid <= 1'b0;
                busy  <= 1'b0;
                done  <= 1'b1;
            end else begin
                state  <= (state == ST_A_ONLY) ? ST_SH_ONLY : ST_A_AND_SH;
                if (take_a)
                    a <= a_draw;
                sh_amt <= sh_draw;
                d_ref  <= d_nxt;
            end
        end
    end

endmodule

// File: tb/tb_shl_stim_gen.sv
// Bench for shl_stim_gen: random ready/start stimulus checked against a
// vector list computed directly from the sequence rules.
module tb_shl_stim_gen;
    import shl_tb_pkg::*;

    localparam int NV = 256;

    logic        clk = 1'b0;
    logic        rst, start, ready, start2, ready2;
    logic [31:0] a, sh_amt, d_ref, a2, sh2, d2;
    logic        valid, busy, done, valid2, busy2, done2;
    logic [15:0] vec_count, vec_count2;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int t0 = 0;
    logic [31:0] m_a[$], m_s[$], m_d[$];
    logic [31:0] tp_a[3], tp_s[3], tp_d[3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    shl_stim_gen #(.DATAWIDTH(32), .NUM_VECTORS(NV), .SEED_A(DEF_SEED_A), .SEED_SH(DEF_SEED_SH)) dut (
        .clk(clk), .rst(rst), .start(start), .ready(ready),
        .a(a), .sh_amt(sh_amt), .d_ref(d_ref),
        .valid(valid), .busy(busy), .done(done), .vec_count(vec_count)
    );

    shl_stim_gen #(.DATAWIDTH(32), .NUM_VECTORS(4), .SEED_A(32'h1), .SEED_SH(32'h1F)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .ready(ready2),
        .a(a2), .sh_amt(sh2), .d_ref(d2),
        .valid(valid2), .busy(busy2), .done(done2), .vec_count(vec_count2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    // Vector i: first is operand-only, second is shift-only, then both.
    task automatic build(input logic [31:0] sa, input logic [31:0] ss, input int n);
        logic [31:0] la, ls, ca, cs;
        la = sa; ls = ss; ca = 0; cs = 0;
        m_a.delete(); m_s.delete(); m_d.delete();
        for (int i = 0; i < n; i++) begin
            if (i != 1) begin ca = la; la = step(la); end
            if (i == 0) cs = 0;
            else begin cs = (ls % 32) + 1; ls = step(ls); end
            m_a.push_back(ca);
            m_s.push_back(cs);
            m_d.push_back(cs >= 32 ? 32'd0 : ca << cs);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_a"}, a, 0);
        chk({tag, "_sh"}, sh_amt, 0);
        chk({tag, "_d"}, d_ref, 0);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_cnt"}, vec_count, 0);
    endtask

    // Runs from IDLE/DONE until n vectors are accepted; optional random ready,
    // start pulses while busy, and start coinciding with the final acceptance.
    task automatic run(input int n, input bit rnd, input bit pulse, input bit tp);
        int k, budget;
        bit stalled;
        logic [31:0] pa, ps, pd;
        k = 0; budget = 0; stalled = 0; pa = 0; ps = 0; pd = 0;
        @(negedge clk);
        start = 1; ready = 1; t0 = cyc;
        while (k < n && budget < 5000) begin
            @(negedge clk);
            budget++;
            if (stalled) begin
                chk("hold_a", a, pa);
                chk("hold_sh", sh_amt, ps);
                chk("hold_d", d_ref, pd);
            end
            chk("valid", valid, 1);
            chk("busy", busy, 1);
            chk("vec_a", a, m_a[k]);
            chk("vec_sh", sh_amt, m_s[k]);
            chk("vec_d", d_ref, m_d[k]);
            chk("vec_cnt", vec_count, k);
            if (tp && k < 3) begin
                chk("plan_a", a, tp_a[k]);
                chk("plan_sh", sh_amt, tp_s[k]);
                chk("plan_d", d_ref, tp_d[k]);
            end
            ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            start = pulse && ($urandom_range(0, 7) == 0);
            if (pulse && ready && k == n - 1) start = 1;
            if (ready) begin
                k++; stalled = 0;
            end else begin
                stalled = 1; pa = a; ps = sh_amt; pd = d_ref;
            end
        end
        if (budget >= 5000) chk("run_timeout", budget, 0);
        @(negedge clk);
        start = 0;
        chk("end_cnt", vec_count, n);
        if (n == NV) begin
            chk("end_done", done, 1);
            chk("end_valid", valid, 0);
            chk("end_busy", busy, 0);
            chk("end_a_held", a, m_a[n-1]);
            if (!rnd) chk("done_latency", cyc - t0, NV + 1);
        end
    endtask

    initial begin
        tp_a[0] = 32'h1; tp_s[0] = 0; tp_d[0] = 32'h1;
        tp_a[1] = 32'h1; tp_s[1] = 4; tp_d[1] = 32'h10;
        tp_a[2] = 32'h8020_0003; tp_s[2] = 3; tp_d[2] = 32'h0100_0018;
        rst = 1; start = 0; ready = 0; start2 = 0; ready2 = 0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        chk("reset_valid2", valid2, 0);
        rst = 0;
        @(negedge clk);
        chk("idle_valid", valid, 0);

        build(DEF_SEED_A, DEF_SEED_SH, NV);
        run(NV, 0, 0, 1);
        repeat (3) @(negedge clk);
        chk("done_held", done, 1);
        chk("done_valid", valid, 0);

        // Restart from DONE with stalls and stray start pulses.
        run(NV, 1, 1, 1);
        run(NV, 1, 0, 1);

        // Abandon a run with reset after 100 accepted vectors.
        run(100, 1, 0, 1);
        rst = 1;
        @(negedge clk);
        chk_zero("midrst");
        rst = 0;
        repeat (2) @(negedge clk);
        chk("no_autostart", valid, 0);
        run(3, 0, 0, 1);
        rst = 1;
        @(negedge clk);
        rst = 0;

        // Shift amount of full width yields zero.
        build(32'h1, 32'h1F, 4);
        @(negedge clk);
        start2 = 1; ready2 = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start2 = 0;
            chk("w_a", a2, m_a[k]);
            chk("w_sh", sh2, m_s[k]);
            chk("w_d", d2, m_d[k]);
            if (k == 1) begin
                chk("w_sh32", sh2, 32);
                chk("w_d0", d2, 0);
            end
        end
        @(negedge clk);
        chk("w_done", done2, 1);
        chk("w_cnt", vec_count2, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/shl_stim_gen.md
# shl_stim_gen

Synthesizable stimulus generator feeding the SHL unit under test and, through `d_ref`/`valid`, the error monitor. Emits a fixed-length, seed-reproducible sequence of (`a`, `sh_amt`) vectors with the matching expected result `d_ref = a << sh_amt`. A three-phase sequence (operand only, shift only, both) exercises each input path in isolation before randomised operation. A ready/valid handshake lets the checker stall the stream.

## Interface
- `DATAWIDTH`, 32, operand/result width; power of two, 8..64.
- `NUM_VECTORS`, 256, vectors per run; must be ≥3.
- `SEED_A`, 32'h0000_0001, operand LFSR seed; nonzero.
- `SEED_SH`, 32'h0000_0003, shift LFSR seed; nonzero.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  run request, sampled in IDLE or DONE.
- `ready`  in  1  downstream accepts the current vector.
- `a`  out  DATAWIDTH  operand to SHL.
- `sh_amt`  out  DATAWIDTH  shift amount to SHL.
- `d_ref`  out  DATAWIDTH  expected SHL result.
- `valid`  out  1  `a`/`sh_amt`/`d_ref` hold a live vector.
- `busy`  out  1  run in progress.
- `done`  out  1  run complete; held until `start` or `rst`.
- `vec_count`  out  16  vectors accepted in the current run.

## Operation
- FSM states: IDLE, A_ONLY, SH_ONLY, A_AND_SH, DONE.
- IDLE/DONE + `start`: both LFSRs reload from seeds, `vec_count` clears to 0, `done` clears, go to A_ONLY with the first vector.
- Draw rule: each draw uses the LFSR's current value, then steps that LFSR once. Operand draw: `a = lfsr_a[DATAWIDTH-1:0]`; for DATAWIDTH=64, `{lfsr_a, lfsr_a}`. Shift draw: `sh_amt = lfsr_s[log2(DATAWIDTH)-1:0] + 1`, zero-extended to DATAWIDTH, range 1..DATAWIDTH.
- A_ONLY vector: new `a`, `sh_amt = 0`, `d_ref = a`.
- SH_ONLY vector: `a` held, new `sh_amt`, `d_ref = a << sh_amt`.
- A_AND_SH vectors: new `a` and new `sh_amt` every vector.
- `d_ref` is truncated to DATAWIDTH bits. `sh_amt == DATAWIDTH` gives `d_ref = 0`.
- LFSR: 32-bit Galois, taps 32'h8020_0003. Step rule: `lsb ? (s>>1) ^ taps : s>>1`.
- Handshake: a vector is accepted on a cycle with `valid && ready`. `vec_count` increments on acceptance, and the next vector (or DONE) loads on the same edge.
- While `valid && !ready`: `a`, `sh_amt`, `d_ref`, FSM and LFSRs all hold.
- Acceptance of vector `NUM_VECTORS`: go to DONE; `valid=0`, `busy=0`, `done=1`. Data outputs hold their last values.
- `start` is ignored while busy.
- `vec_count` saturates at 16'hFFFF.

## Timing
- Reset values: `a=0`, `sh_amt=0`, `d_ref=0`, `valid=0`, `busy=0`, `done=0`, `vec_count=0`; FSM in IDLE.
- `rst` mid-run: reset values appear the next cycle; the run is abandoned and `start` must be reissued.
- `start` at edge N → first vector, `valid=1`, `busy=1` at N+1.
- With `ready` held high, one vector per cycle; the last vector is valid at N+NUM_VECTORS and `done=1` at N+NUM_VECTORS+1.
- All outputs are registered; no combinational path from inputs to outputs.
- `start` and the final acceptance in the same cycle: the final acceptance wins (go to DONE). `start` is honoured only on a later cycle in DONE.

## Structure
- Shared package `shl_tb_pkg`: FSM state encoding, `LFSR_TAPS`, default seeds.
- Sub-module `lfsr32` (load, step enable, seed input, state output), instantiated twice: `lfsr_a_i` and `lfsr_s_i`.
- The top level holds the FSM, handshake, counters and `d_ref` computation.

## Test plan
- Reset then `start`, `ready=1`, defaults:
  - vector 1: `a=1`, `sh_amt=0`, `d_ref=1`.
  - vector 2: `a=1`, `sh_amt=4`, `d_ref=32'h10`.
  - vector 3: `a=32'h8020_0003`, `sh_amt=3`, `d_ref=32'h0100_0018`.
- Run of 256 with `ready=1`: `done=1` exactly 257 cycles after `start`, `vec_count=256`, and the error monitor flags no errors against SHL.
- `ready` low for 5 cycles after vector 2: outputs are stable for all 5 cycles, then the sequence resumes with vector 3 as above.
- `rst` asserted at vector 100: all outputs return to zero next cycle. A restart reproduces vector 1 = (1, 0, 1).
- `start` pulsed while busy: no effect. `start` in DONE: identical first three vectors.
- Force `sh_amt` to 32 (seed chosen so `lfsr_s[4:0]=31`): `d_ref=0` and SHL matches.
